// File: rtl/axil_cfg_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to cfg_bus bridge.
//   - cfg_req_t      : request half of the cfg_bus (address + write data)
//   - bridge_state_e : bridge FSM states
//   - AXI_OKAY/AXI_SLVERR : AXI response codes
//   - TIMEOUT_CYCLES_DEF  : default ack timeout
package axil_cfg_bridge_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 256;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    // Request payload driven onto the cfg_bus; strobes are decoded from state.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } cfg_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } bridge_state_e;

endpackage

// File: rtl/axil_cfg_bridge.sv
// AXI4-Lite slave that turns each read or write into a single cfg_bus
// rd/wr strobe, waits for cfg_ack and returns the result as an R or B
// response. A missing ack ends in SLVERR after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*       AXI-Lite write address/data/response channels
//   s_ar*/s_r*            AXI-Lite read address/data channels
//   cfg_addr/cfg_wdata    cfg_bus request payload, stable while waiting
//   cfg_wr/cfg_rd         one-cycle request strobes
//   cfg_ack/cfg_rdata     responder completion and read data
//   timeout_cnt           saturating count of timed-out requests
module axil_cfg_bridge
    import axil_cfg_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_DEAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic [31:0] cfg_addr,
    output logic [31:0] cfg_wdata,
    output logic        cfg_wr,
    output logic        cfg_rd,
    input  logic        cfg_ack,
    input  logic [31:0] cfg_rdata,
    output logic [15:0] timeout_cnt
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    bridge_state_e state, state_nxt;

    logic        aw_held, w_held, ar_held;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic        cur_rd;     // transaction in flight is a read
    logic        prio_rd;    // read wins the next write/read contention
    logic [15:0] timer;
    cfg_req_t    req_q;
    logic [1:0]  resp_q;
    logic [31:0] rdata_q;

    logic wr_elig, rd_elig, start, pick_rd, timer_last, resp_hs;

    // Byte strobes are deliberately ignored: every write is a full word.
    logic unused_wstrb;
    assign unused_wstrb = ^s_wstrb;

    assign wr_elig    = aw_held & w_held;
    assign rd_elig    = ar_held;
    assign start      = (state == ST_IDLE) & (wr_elig | rd_elig);
    // An AR that is valid but not yet accepted cannot be served, so only a
    // held AR competes with an eligible write.
    assign pick_rd    = rd_elig & (~wr_elig | prio_rd);
    // The timer reads 0 during REQ and counts cycles since the strobe, so the
    // response appears exactly TIMEOUT_CYCLES after the strobe.
    assign timer_last = (timer == TIMER_LAST);
    assign resp_hs    = (s_bvalid & s_bready) | (s_rvalid & s_rready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ:  state_nxt = ST_WAIT;
            ST_WAIT: if (cfg_ack || timer_last) state_nxt = ST_RESP;
            ST_RESP: if (resp_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_arready = 1'b0;
        if (!rst && state == ST_IDLE) begin
            s_awready = ~aw_held;
            s_wready  = ~w_held;
            s_arready = ~(aw_held | w_held | ar_held);
        end
        cfg_wr   = (state == ST_REQ)  & ~cur_rd;
        cfg_rd   = (state == ST_REQ)  &  cur_rd;
        s_bvalid = (state == ST_RESP) & ~cur_rd;
        s_rvalid = (state == ST_RESP) &  cur_rd;
    end

    assign cfg_addr  = req_q.addr;
    assign cfg_wdata = req_q.wdata;
    assign s_bresp   = resp_q;
    assign s_rresp   = resp_q;
    assign s_rdata   = rdata_q;

    // Channel capture, request/response datapath, timer and arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            ar_held     <= 1'b0;
            aw_addr     <= '0;
            w_data      <= '0;
            ar_addr     <= '0;
            cur_rd      <= 1'b0;
            prio_rd     <= 1'b0;
            timer       <= '0;
            req_q       <= '0;
            resp_q      <= AXI_OKAY;
            rdata_q     <= '0;
            timeout_cnt <= '0;
        end else begin
            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
            end
            if (s_arvalid && s_arready) begin
                ar_held <= 1'b1;
                ar_addr <= s_araddr;
            end

            case (state)
                ST_IDLE: if (start) begin
                    cur_rd     <= pick_rd;
                    req_q.addr <= pick_rd ? ar_addr : aw_addr;
                    if (!pick_rd) req_q.wdata <= w_data;
                    timer      <= '0;
                    // Priority flips only when both types actually competed.
                    if (wr_elig && rd_elig) prio_rd <= ~pick_rd;
                end
                ST_REQ: timer <= timer + 16'd1;
                ST_WAIT: begin
                    if (cfg_ack) begin
                        // Ack on the timeout cycle still counts as success.
                        resp_q  <= AXI_OKAY;
                        rdata_q <= cfg_rdata;
                    end else if (timer_last) begin
                        resp_q  <= AXI_SLVERR;
                        rdata_q <= ERR_RDATA;
                        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                ST_RESP: if (resp_hs) begin
                    // Only the served halves are released; a write half
                    // captured while a read was in flight stays held.
                    if (cur_rd) ar_held <= 1'b0;
                    else begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
